// File: rtl/coso_match_pkg.sv
// Shared types and widths for the coherent-sampler RO match controller.
package coso_match_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACQ   = 2'd1,
    ST_MATCH = 2'd2,
    ST_FAIL  = 2'd3
  } state_e;

  localparam int unsigned DEF_SEL_W    = 12;
  localparam int unsigned DEF_SAMP_LOG = 7;
  // Extra bit so a good count (and last_good) can hold a full window of 2^SAMP_LOG.
  localparam int unsigned GOOD_XTRA_W  = 1;

endpackage

// File: rtl/coso_match_window.sv
// Evaluation window: counts accepted and in-range samples, flags the last sample of a window.
module coso_match_window
  import coso_match_pkg::*;
#(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned CHK_W    = 10,
  parameter int unsigned SAMP_LOG = DEF_SAMP_LOG
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr_i,
  input  logic                         acc_i,
  input  logic [CNT_W-1:0]             cnt_i,
  input  logic [CHK_W-1:0]             thr_lo_i,
  input  logic [CHK_W-1:0]             thr_hi_i,
  output logic                         win_end_c_o,
  output logic [SAMP_LOG+GOOD_XTRA_W-1:0] good_tot_c_o
);

  localparam int unsigned GOOD_W = SAMP_LOG + GOOD_XTRA_W;

  logic [CHK_W-1:0]    msb_c;
  logic                good_c;
  logic                unused_cnt_c;
  logic [SAMP_LOG-1:0] samp_q, samp_d;
  logic [GOOD_W-1:0]   good_q, good_d;

  assign msb_c        = cnt_i[CNT_W-1 -: CHK_W];
  assign unused_cnt_c = ^cnt_i;
  // An empty or inverted range never matches.
  assign good_c       = (msb_c >= thr_lo_i) && (msb_c < thr_hi_i);
  assign win_end_c_o  = acc_i && (samp_q == '1);
  assign good_tot_c_o = good_q + GOOD_W'(acc_i && good_c);

  always_comb begin
    samp_d = samp_q;
    good_d = good_q;
    if (clr_i || win_end_c_o) begin
      samp_d = '0;
      good_d = '0;
    end else if (acc_i) begin
      samp_d = samp_q + SAMP_LOG'(1);
      good_d = good_tot_c_o;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_q <= '0;
      good_q <= '0;
    end else begin
      samp_q <= samp_d;
      good_q <= good_d;
    end
  end

endmodule

// File: rtl/coso_match_ctrl.sv
// Sweeps RO configurations until the coherent-sampler count sits in range for a window.
// Optional stats outputs (last_good, tries) are built when COSO_MATCH_STATS_EN is defined.
module coso_match_ctrl
  import coso_match_pkg::*;
#(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned CHK_W    = 10,
  parameter int unsigned SEL_W    = DEF_SEL_W,
  parameter int unsigned SAMP_LOG = DEF_SAMP_LOG,
  parameter int unsigned LOCK_LOG = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [SEL_W-1:0]    sel_start,
  input  logic                wrap_en,
  input  logic [CHK_W-1:0]    thr_lo,
  input  logic [CHK_W-1:0]    thr_hi,
  input  logic [SAMP_LOG:0]   samp_min,
  input  logic [SAMP_LOG:0]   samp_drop,
  input  logic [CNT_W-1:0]    cs_cnt,
  input  logic                cs_req,
  output logic                cs_ack,
  output logic [SEL_W-1:0]    ro_sel,
  output logic                matched,
  output logic                no_found,
  output logic                locked,
  output logic                busy
`ifdef COSO_MATCH_STATS_EN
  ,
  output logic [SAMP_LOG+GOOD_XTRA_W-1:0] last_good,
  output logic [SEL_W-1:0]                tries
`endif
);

  localparam int unsigned GOOD_W = SAMP_LOG + GOOD_XTRA_W;
  // Value just before all-ones: the idle cycle seen at this count is the timeout.
  localparam logic [LOCK_LOG-1:0] LOCK_LAST = LOCK_LOG'((1 << LOCK_LOG) - 2);

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    ro_sel_q, ro_sel_d;
  logic [LOCK_LOG-1:0] lock_q, lock_d;
  logic                ack_q, matched_q, matched_d, no_found_q, no_found_d;
  logic                locked_q, locked_d, busy_q;

  logic                active_c, take_c, acc_c, lock_to_c, win_clr_c;
  logic                win_end_c, acq_hit_c, adv_c, sel_top_c;
  logic [GOOD_W-1:0]   good_tot_c;

  assign active_c  = (state_q == ST_ACQ) || (state_q == ST_MATCH);
  assign take_c    = cs_req && !ack_q;
  assign acc_c     = take_c && active_c && !start;
  assign lock_to_c = active_c && !start && !acc_c && (lock_q == LOCK_LAST);
  assign win_clr_c = start || lock_to_c;
  assign sel_top_c = (ro_sel_q == '1);

  coso_match_window #(
    .CNT_W   (CNT_W),
    .CHK_W   (CHK_W),
    .SAMP_LOG(SAMP_LOG)
  ) u_window (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (win_clr_c),
    .acc_i       (acc_c),
    .cnt_i       (cs_cnt),
    .thr_lo_i    (thr_lo),
    .thr_hi_i    (thr_hi),
    .win_end_c_o (win_end_c),
    .good_tot_c_o(good_tot_c)
  );

  // Window verdicts; win_end_c implies an accepted sample, so start is already excluded.
  assign acq_hit_c = (state_q == ST_ACQ) && win_end_c && (good_tot_c >= samp_min);
  assign adv_c     = ((state_q == ST_ACQ)   && win_end_c && (good_tot_c <  samp_min)) ||
                     ((state_q == ST_MATCH) && win_end_c && (good_tot_c <  samp_drop)) ||
                     lock_to_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ro_sel_q   <= '0;
      lock_q     <= '0;
      ack_q      <= 1'b0;
      matched_q  <= 1'b0;
      no_found_q <= 1'b0;
      locked_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ro_sel_q   <= ro_sel_d;
      lock_q     <= lock_d;
      ack_q      <= take_c;
      matched_q  <= matched_d;
      no_found_q <= no_found_d;
      locked_q   <= locked_d;
      busy_q     <= (state_d == ST_ACQ) || (state_d == ST_MATCH);
    end
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = ST_ACQ;
    end else if (adv_c) begin
      state_d = (sel_top_c && !wrap_en) ? ST_FAIL : ST_ACQ;
    end else if (acq_hit_c) begin
      state_d = ST_MATCH;
    end
  end

  always_comb begin
    ro_sel_d   = ro_sel_q;
    lock_d     = lock_q;
    matched_d  = matched_q;
    no_found_d = no_found_q;
    locked_d   = locked_q;
    if (start) begin
      ro_sel_d   = sel_start;
      lock_d     = '0;
      matched_d  = 1'b0;
      no_found_d = 1'b0;
      locked_d   = 1'b0;
    end else begin
      if (acc_c) begin
        lock_d   = '0;
        locked_d = 1'b0;
      end else if (lock_to_c) begin
        lock_d   = '0;
        locked_d = 1'b1;
      end else if (active_c) begin
        lock_d = lock_q + LOCK_LOG'(1);
      end else begin
        lock_d = '0;
      end
      if (acq_hit_c) begin
        matched_d = 1'b1;
      end
      // Advance: step the configuration, or wrap/stop at the end of the sweep.
      if (adv_c) begin
        matched_d = 1'b0;
        if (sel_top_c) begin
          no_found_d = 1'b1;
          if (wrap_en) begin
            ro_sel_d = '0;
          end
        end else begin
          ro_sel_d = ro_sel_q + SEL_W'(1);
        end
      end
    end
  end

  assign cs_ack   = ack_q;
  assign ro_sel   = ro_sel_q;
  assign matched  = matched_q;
  assign no_found = no_found_q;
  assign locked   = locked_q;
  assign busy     = busy_q;

`ifdef COSO_MATCH_STATS_EN
  logic [GOOD_W-1:0] last_good_q;
  logic [SEL_W-1:0]  tries_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_good_q <= '0;
      tries_q     <= '0;
    end else begin
      if (win_end_c) begin
        last_good_q <= good_tot_c;
      end
      if (start) begin
        tries_q <= '0;
      end else if (adv_c && (tries_q != '1)) begin
        tries_q <= tries_q + SEL_W'(1);
      end
    end
  end

  assign last_good = last_good_q;
  assign tries     = tries_q;
`endif

endmodule

// File: tb/tb_coso_match_ctrl.sv
// Self-checking bench for coso_match_ctrl: directed scenarios plus randomized sweeps vs. a window-level model.
module tb_coso_match_ctrl;

  localparam int unsigned CNT_W    = 16;
  localparam int unsigned CHK_W    = 10;
  localparam int unsigned SEL_W    = 4;
  localparam int unsigned SAMP_LOG = 3;
  localparam int unsigned LOCK_LOG = 4;
  localparam int unsigned LSB_W    = CNT_W - CHK_W;
  localparam int          SEL_MAX  = (1 << SEL_W) - 1;
  localparam int          WIN      = 1 << SAMP_LOG;

  logic                clk = 1'b0;
  logic                rst, start, wrap_en, cs_req;
  logic [SEL_W-1:0]    sel_start;
  logic [CHK_W-1:0]    thr_lo, thr_hi;
  logic [SAMP_LOG:0]   samp_min, samp_drop;
  logic [CNT_W-1:0]    cs_cnt;
  logic                cs_ack, matched, no_found, locked, busy;
  logic [SEL_W-1:0]    ro_sel;
`ifdef COSO_MATCH_STATS_EN
  logic [SAMP_LOG:0]   last_good;
  logic [SEL_W-1:0]    tries;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int ack_cnt = 0;

  // Window-level reference model
  int m_mode;  // 0 idle, 1 acquiring, 2 matched, 3 failed
  int m_sel, m_matched, m_no_found, m_tries, m_last_good;

  always #5 clk = ~clk;

  always @(negedge clk) if (cs_ack) ack_cnt++;

  coso_match_ctrl #(
    .CNT_W(CNT_W), .CHK_W(CHK_W), .SEL_W(SEL_W), .SAMP_LOG(SAMP_LOG), .LOCK_LOG(LOCK_LOG)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .sel_start(sel_start), .wrap_en(wrap_en),
    .thr_lo(thr_lo), .thr_hi(thr_hi), .samp_min(samp_min), .samp_drop(samp_drop),
    .cs_cnt(cs_cnt), .cs_req(cs_req), .cs_ack(cs_ack), .ro_sel(ro_sel),
    .matched(matched), .no_found(no_found), .locked(locked), .busy(busy)
`ifdef COSO_MATCH_STATS_EN
    , .last_good(last_good), .tries(tries)
`endif
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rand_bad();
    if ($urandom_range(0, 1) == 1) return int'($urandom_range(0, 255));
    return int'($urandom_range(512, 1023));
  endfunction

  task automatic send_sample(input int msb);
    bit got = 1'b0;
    cs_cnt = {CHK_W'(msb), LSB_W'($urandom)};
    cs_req = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      if (cs_ack) got = 1'b1;
    end
    cs_req = 1'b0;
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL ack_timeout: cs_ack=0 after 8 cycles, required 1");
    end
  endtask

  task automatic send_window(input int n_good);
    for (int i = 0; i < WIN; i++)
      send_sample(i < n_good ? int'($urandom_range(256, 511)) : rand_bad());
  endtask

  task automatic pulse_start(input int sel);
    sel_start = SEL_W'(sel);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic set_defaults();
    thr_lo = CHK_W'(256); thr_hi = CHK_W'(512);
    samp_min = 4'd6; samp_drop = 4'd2;
  endtask

  function automatic void model_start(input int sel);
    m_mode = 1; m_sel = sel; m_matched = 0; m_no_found = 0; m_tries = 0;
  endfunction

  function automatic void model_advance(input int wrap);
    if (m_tries < SEL_MAX) m_tries++;
    m_matched = 0;
    if (m_sel == SEL_MAX) begin
      m_no_found = 1;
      if (wrap != 0) begin m_sel = 0; m_mode = 1; end
      else m_mode = 3;
    end else begin
      m_sel++;
      m_mode = 1;
    end
  endfunction

  function automatic void model_window(input int good, input int wrap, input int smin, input int sdrop);
    if (m_mode == 1 || m_mode == 2) m_last_good = good;
    if (m_mode == 1) begin
      if (good >= smin) begin m_mode = 2; m_matched = 1; end
      else model_advance(wrap);
    end else if (m_mode == 2) begin
      if (good < sdrop) model_advance(wrap);
    end
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; cs_req = 1'b1; wrap_en = 1'b0;
    sel_start = 4'd9; cs_cnt = 16'hFFFF; set_defaults();
    tick(); tick();
    n_tests += 6;
    if (cs_ack !== 1'b0)   begin n_fail++; $display("FAIL reset_ack: got %b expected 0", cs_ack); end
    if (ro_sel !== 4'd0)   begin n_fail++; $display("FAIL reset_ro_sel: got %0d expected 0", ro_sel); end
    if (matched !== 1'b0)  begin n_fail++; $display("FAIL reset_matched: got %b expected 0", matched); end
    if (no_found !== 1'b0) begin n_fail++; $display("FAIL reset_no_found: got %b expected 0", no_found); end
    if (locked !== 1'b0)   begin n_fail++; $display("FAIL reset_locked: got %b expected 0", locked); end
    if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst = 1'b0; start = 1'b0; cs_req = 1'b0;
    tick();
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_match();
    int a0;
    wrap_en = 1'b0;
    pulse_start(5);
    a0 = ack_cnt;
    for (int i = 0; i < WIN - 1; i++) send_sample(300);
    n_tests++;
    if (matched !== 1'b0) begin n_fail++; $display("FAIL match_early: got %b expected 0 after 7 samples", matched); end
    send_sample(300);
    n_tests += 3;
    if (matched !== 1'b1)  begin n_fail++; $display("FAIL match_set: got %b expected 1", matched); end
    if (ro_sel !== 4'd5)   begin n_fail++; $display("FAIL match_ro_sel: got %0d expected 5", ro_sel); end
    if (busy !== 1'b1)     begin n_fail++; $display("FAIL match_busy: got %b expected 1", busy); end
    tick();
    n_tests++;
    if (ack_cnt - a0 != WIN) begin n_fail++; $display("FAIL match_acks: got %0d expected %0d", ack_cnt - a0, WIN); end
  endtask

  task automatic test_unmatch();
    send_window(2);
    n_tests += 2;
    if (matched !== 1'b1) begin n_fail++; $display("FAIL hold_matched: got %b expected 1", matched); end
    if (ro_sel !== 4'd5)  begin n_fail++; $display("FAIL hold_ro_sel: got %0d expected 5", ro_sel); end
    send_window(1);
    n_tests += 3;
    if (matched !== 1'b0) begin n_fail++; $display("FAIL drop_matched: got %b expected 0", matched); end
    if (ro_sel !== 4'd6)  begin n_fail++; $display("FAIL drop_ro_sel: got %0d expected 6", ro_sel); end
    if (busy !== 1'b1)    begin n_fail++; $display("FAIL drop_busy: got %b expected 1", busy); end
    // Back in ACQ, 5 good is below samp_min and advances again
    send_window(5);
    n_tests++;
    if (ro_sel !== 4'd7) begin n_fail++; $display("FAIL acq_after_drop: got %0d expected 7", ro_sel); end
  endtask

  task automatic test_fail_wrap();
    wrap_en = 1'b0;
    pulse_start(15);
    send_window(0);
    n_tests += 4;
    if (busy !== 1'b0)     begin n_fail++; $display("FAIL nowrap_busy: got %b expected 0", busy); end
    if (no_found !== 1'b1) begin n_fail++; $display("FAIL nowrap_no_found: got %b expected 1", no_found); end
    if (ro_sel !== 4'd15)  begin n_fail++; $display("FAIL nowrap_ro_sel: got %0d expected 15", ro_sel); end
    if (matched !== 1'b0)  begin n_fail++; $display("FAIL nowrap_matched: got %b expected 0", matched); end
    send_window(WIN);
    n_tests += 2;
    if (matched !== 1'b0) begin n_fail++; $display("FAIL stuck_matched: got %b expected 0", matched); end
    if (ro_sel !== 4'd15) begin n_fail++; $display("FAIL stuck_ro_sel: got %0d expected 15", ro_sel); end
    wrap_en = 1'b1;
    pulse_start(15);
    n_tests++;
    if (no_found !== 1'b0) begin n_fail++; $display("FAIL start_clr_no_found: got %b expected 0", no_found); end
    send_window(0);
    n_tests += 3;
    if (ro_sel !== 4'd0)   begin n_fail++; $display("FAIL wrap_ro_sel: got %0d expected 0", ro_sel); end
    if (busy !== 1'b1)     begin n_fail++; $display("FAIL wrap_busy: got %b expected 1", busy); end
    if (no_found !== 1'b1) begin n_fail++; $display("FAIL wrap_no_found: got %b expected 1", no_found); end
    send_window(0);
    n_tests += 2;
    if (ro_sel !== 4'd1)   begin n_fail++; $display("FAIL wrap_next_ro_sel: got %0d expected 1", ro_sel); end
    if (no_found !== 1'b1) begin n_fail++; $display("FAIL sticky_no_found: got %b expected 1", no_found); end
  endtask

  task automatic test_lock();
    wrap_en = 1'b0;
    pulse_start(9);
    send_window(WIN);
    repeat (14) tick();
    n_tests += 2;
    if (locked !== 1'b0) begin n_fail++; $display("FAIL lock_early: got %b expected 0 after 14 idle", locked); end
    if (ro_sel !== 4'd9) begin n_fail++; $display("FAIL lock_early_sel: got %0d expected 9", ro_sel); end
    tick();
    n_tests += 4;
    if (locked !== 1'b1)  begin n_fail++; $display("FAIL lock_set: got %b expected 1", locked); end
    if (ro_sel !== 4'd10) begin n_fail++; $display("FAIL lock_ro_sel: got %0d expected 10", ro_sel); end
    if (matched !== 1'b0) begin n_fail++; $display("FAIL lock_matched: got %b expected 0", matched); end
    if (busy !== 1'b1)    begin n_fail++; $display("FAIL lock_busy: got %b expected 1", busy); end
    send_sample(300);
    n_tests++;
    if (locked !== 1'b0) begin n_fail++; $display("FAIL lock_clear: got %b expected 0", locked); end
  endtask

  task automatic test_start_collision();
    wrap_en = 1'b0;
    pulse_start(3);
    for (int i = 0; i < 3; i++) send_sample(300);
    tick();
    sel_start = 4'd3; start = 1'b1; cs_req = 1'b1; cs_cnt = {CHK_W'(300), LSB_W'(0)};
    tick();
    start = 1'b0; cs_req = 1'b0;
    n_tests += 2;
    if (cs_ack !== 1'b1) begin n_fail++; $display("FAIL collide_ack: got %b expected 1", cs_ack); end
    if (ro_sel !== 4'd3) begin n_fail++; $display("FAIL collide_ro_sel: got %0d expected 3", ro_sel); end
    for (int i = 0; i < WIN - 1; i++) send_sample(300);
    n_tests++;
    if (matched !== 1'b0) begin n_fail++; $display("FAIL collide_counted: got %b expected 0", matched); end
    send_sample(300);
    n_tests++;
    if (matched !== 1'b1) begin n_fail++; $display("FAIL collide_window: got %b expected 1", matched); end
  endtask

  task automatic test_rst_mid();
    wrap_en = 1'b1;
    pulse_start(2);
    for (int i = 0; i < 4; i++) send_sample(300);
    rst = 1'b1; start = 1'b1; cs_req = 1'b1;
    tick();
    n_tests += 6;
    if (cs_ack !== 1'b0)   begin n_fail++; $display("FAIL rst_ack: got %b expected 0", cs_ack); end
    if (ro_sel !== 4'd0)   begin n_fail++; $display("FAIL rst_ro_sel: got %0d expected 0", ro_sel); end
    if (matched !== 1'b0)  begin n_fail++; $display("FAIL rst_matched: got %b expected 0", matched); end
    if (no_found !== 1'b0) begin n_fail++; $display("FAIL rst_no_found: got %b expected 0", no_found); end
    if (locked !== 1'b0)   begin n_fail++; $display("FAIL rst_locked: got %b expected 0", locked); end
    if (busy !== 1'b0)     begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
    rst = 1'b0; start = 1'b0; cs_req = 1'b0;
    tick();
    send_window(WIN);
    n_tests += 3;
    if (busy !== 1'b0)    begin n_fail++; $display("FAIL idle_discard_busy: got %b expected 0", busy); end
    if (matched !== 1'b0) begin n_fail++; $display("FAIL idle_discard_matched: got %b expected 0", matched); end
    if (ro_sel !== 4'd0)  begin n_fail++; $display("FAIL idle_discard_ro_sel: got %0d expected 0", ro_sel); end
  endtask

`ifdef COSO_MATCH_STATS_EN
  task automatic test_stats();
    wrap_en = 1'b0;
    pulse_start(0);
    n_tests++;
    if (tries !== 4'd0) begin n_fail++; $display("FAIL stats_tries0: got %0d expected 0", tries); end
    send_window(1);
    n_tests++;
    if (last_good !== 4'd1) begin n_fail++; $display("FAIL stats_last1: got %0d expected 1", last_good); end
    send_window(3);
    send_window(5);
    n_tests += 3;
    if (tries !== 4'd3)     begin n_fail++; $display("FAIL stats_tries: got %0d expected 3", tries); end
    if (last_good !== 4'd5) begin n_fail++; $display("FAIL stats_last: got %0d expected 5", last_good); end
    if (ro_sel !== 4'd3)    begin n_fail++; $display("FAIL stats_ro_sel: got %0d expected 3", ro_sel); end
  endtask
`endif

  task automatic test_random();
    for (int ep = 0; ep < 8; ep++) begin
      int lo, hi, smin, sdrop, wrap, sel;
      if ($urandom_range(0, 3) == 0) begin
        lo = 256; hi = 512;
      end else begin
        lo = int'($urandom_range(0, 1023));
        hi = int'($urandom_range(0, 1023));
      end
      smin  = int'($urandom_range(0, WIN));
      sdrop = int'($urandom_range(0, WIN));
      wrap  = int'($urandom_range(0, 1));
      sel   = int'($urandom_range(10, SEL_MAX));
      thr_lo = CHK_W'(lo); thr_hi = CHK_W'(hi);
      samp_min = 4'(smin); samp_drop = 4'(sdrop); wrap_en = wrap[0];
      pulse_start(sel);
      model_start(sel);
      for (int w = 0; w < 10; w++) begin
        int g = 0;
        int pg = int'($urandom_range(0, 8));
        for (int s = 0; s < WIN; s++) begin
          int msb;
          if (lo < hi && int'($urandom_range(0, 7)) < pg) msb = int'($urandom_range(lo, hi - 1));
          else msb = int'($urandom_range(0, 1023));
          if (msb >= lo && msb < hi) g++;
          repeat ($urandom_range(0, 3)) tick();
          send_sample(msb);
        end
        model_window(g, wrap, smin, sdrop);
        n_tests += 5;
        if (matched !== 1'(m_matched))   begin n_fail++; $display("FAIL rnd_matched ep%0d w%0d: got %b expected %0d", ep, w, matched, m_matched); end
        if (ro_sel !== SEL_W'(m_sel))    begin n_fail++; $display("FAIL rnd_ro_sel ep%0d w%0d: got %0d expected %0d", ep, w, ro_sel, m_sel); end
        if (no_found !== 1'(m_no_found)) begin n_fail++; $display("FAIL rnd_no_found ep%0d w%0d: got %b expected %0d", ep, w, no_found, m_no_found); end
        if (busy !== 1'(m_mode == 1 || m_mode == 2)) begin n_fail++; $display("FAIL rnd_busy ep%0d w%0d: got %b expected mode %0d", ep, w, busy, m_mode); end
        if (locked !== 1'b0)             begin n_fail++; $display("FAIL rnd_locked ep%0d w%0d: got %b expected 0", ep, w, locked); end
`ifdef COSO_MATCH_STATS_EN
        n_tests += 2;
        if (tries !== SEL_W'(m_tries))         begin n_fail++; $display("FAIL rnd_tries ep%0d w%0d: got %0d expected %0d", ep, w, tries, m_tries); end
        if (last_good !== 4'(m_last_good))     begin n_fail++; $display("FAIL rnd_last_good ep%0d w%0d: got %0d expected %0d", ep, w, last_good, m_last_good); end
`endif
      end
    end
  endtask

  initial begin
    m_mode = 0; m_sel = 0; m_matched = 0; m_no_found = 0; m_tries = 0; m_last_good = 0;
    test_reset();
    test_match();
    test_unmatch();
    test_fail_wrap();
    test_lock();
    test_start_collision();
    test_rst_mid();
`ifdef COSO_MATCH_STATS_EN
    test_stats();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
